// File: rtl/rom_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_loader_pkg
//  Description : Shared definitions for the boot ROM loader: loader state
//                encoding, image-header byte count and checksum width.
//                The CSUM state exists only when ROM_LOADER_CHECKSUM_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package rom_loader_pkg;

    // Bytes in the length header, which is also the byte count of one word.
    localparam int c_HDR_BYTES = 4;
    // Width of the data words and of the image checksum.
    localparam int c_CSUM_W    = 32;
    // Width of the byte-within-word counter.
    localparam int c_BCNT_W    = $clog2(c_HDR_BYTES);

    typedef enum logic [2:0] {
        ST_LEN   = 3'd0,
        ST_DATA  = 3'd1,
        ST_WRITE = 3'd2,
`ifdef ROM_LOADER_CHECKSUM_EN
        ST_CSUM  = 3'd3,
`endif
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

endpackage : rom_loader_pkg
`default_nettype wire

// File: rtl/rom_loader_asm.sv
`default_nettype none
// ============================================================================
//  Module      : rom_loader_asm
//  Description : Little-endian byte-to-word assembler. Shifts accepted
//                bytes in from the top so the first byte lands in bits 7:0,
//                flags the byte that completes a word and presents the
//                completed word combinationally in that same cycle.
//  Ports       : clk      - clock
//                rst      - asynchronous reset, active low
//                i_valid  - byte accepted this cycle
//                i_data   - accepted byte
//                o_cnt    - bytes of the current word already held
//                o_last   - this accepted byte completes a word
//                o_word   - word including the byte on i_data
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_loader_asm
    import rom_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic [7:0]          i_data,
    output logic [c_BCNT_W-1:0] o_cnt,
    output logic                o_last,
    output logic [c_CSUM_W-1:0] o_word
);

    logic [c_CSUM_W-1:0] r_word;
    logic [c_BCNT_W-1:0] r_cnt;

    assign o_word = {i_data, r_word[c_CSUM_W-1:8]};
    assign o_last = i_valid && (r_cnt == c_BCNT_W'(c_HDR_BYTES - 1));
    assign o_cnt  = r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_valid) begin
            r_word <= o_word;
            r_cnt  <= o_last ? '0 : r_cnt + c_BCNT_W'(1);
        end
    end

endmodule : rom_loader_asm
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : rom_loader
//  Description : Receives a boot image over a byte stream (4-byte LE word
//                count N, then N LE 32-bit words), writes it word by word
//                into the instruction ROM and then releases the core reset.
//                Malformed length or a stalled stream ends in a sticky
//                error with the core held in reset.
//                Optional build macro ROM_LOADER_CHECKSUM_EN: a 4-byte LE
//                checksum (32-bit wrap-around sum of the words) follows the
//                image and must match before the core is released.
//  Ports       : clk        - clock, all state on the rising edge
//                rst        - asynchronous reset, active low
//                s_valid    - stream byte valid
//                s_data     - stream byte
//                s_ready    - stream byte accepted when s_valid && s_ready
//                rom_we     - one-cycle ROM write strobe
//                rom_waddr  - ROM word address
//                rom_wdata  - ROM write word
//                core_rst_n - core reset, low holds the core in reset
//                done       - image loaded, core released
//                err        - load failed, sticky until reset
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              err
);

    localparam int          c_TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [32:0] c_DEPTH = 33'(1) << ADDR_W;
`ifdef ROM_LOADER_CHECKSUM_EN
    localparam state_t      c_ST_END = ST_CSUM;
`else
    localparam state_t      c_ST_END = ST_DONE;
`endif

    state_t                r_state;
    state_t                w_next;
    logic                  r_run;
    logic [ADDR_W:0]       r_len;
    logic [ADDR_W:0]       r_idx;
    logic [ADDR_W:0]       w_idx_inc;
    logic [ADDR_W-1:0]     r_waddr;
    logic [31:0]           r_wdata;
    logic [c_TMO_W-1:0]    r_tmo;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_tmo_en;
    logic                  w_tmo_hit;
    logic [c_BCNT_W-1:0]   w_cnt;
    logic [c_CSUM_W-1:0]   w_word;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [c_CSUM_W-1:0]   r_sum;
`endif

    // r_run keeps s_ready low while reset is asserted even though the
    // state register already sits in LEN.
    assign s_ready   = r_run && ((r_state == ST_LEN) || (r_state == ST_DATA)
`ifdef ROM_LOADER_CHECKSUM_EN
                                 || (r_state == ST_CSUM)
`endif
                                );
    assign w_accept  = s_valid && s_ready;
    assign w_idx_inc = r_idx + (ADDR_W + 1)'(1);
    assign rom_waddr = r_waddr;
    assign rom_wdata = r_wdata;

    rom_loader_asm u_asm (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_accept),
        .i_data  (s_data),
        .o_cnt   (w_cnt),
        .o_last  (w_last),
        .o_word  (w_word)
    );

    // The idle timer runs while a word is expected; in LEN only after the
    // first length byte so an idle link before a load never errors.
    always_comb begin
        w_tmo_en = 1'b0;
        case (r_state)
            ST_LEN:  w_tmo_en = (w_cnt != '0);
            ST_DATA: w_tmo_en = 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
            ST_CSUM: w_tmo_en = 1'b1;
`endif
            default: w_tmo_en = 1'b0;
        endcase
    end

    assign w_tmo_hit = w_tmo_en && !w_accept && (r_tmo == c_TMO_W'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_LEN;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        rom_we     = 1'b0;
        done       = 1'b0;
        core_rst_n = 1'b0;
        err        = 1'b0;
        case (r_state)
            ST_LEN: begin
                if (w_tmo_hit) begin
                    w_next = ST_ERR;
                end else if (w_last) begin
                    if (w_word == '0) begin
                        w_next = c_ST_END;
                    end else if ({1'b0, w_word} > c_DEPTH) begin
                        w_next = ST_ERR;
                    end else begin
                        w_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_tmo_hit) begin
                    w_next = ST_ERR;
                end else if (w_last) begin
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                rom_we = 1'b1;
                w_next = (w_idx_inc == r_len) ? c_ST_END : ST_DATA;
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (w_tmo_hit) begin
                    w_next = ST_ERR;
                end else if (w_last) begin
                    w_next = (w_word == r_sum) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE: begin
                done       = 1'b1;
                core_rst_n = 1'b1;
            end
            ST_ERR: begin
                err = 1'b1;
            end
            default: begin
                w_next = ST_ERR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: length, word index, write word, idle timer, checksum
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run   <= 1'b0;
            r_len   <= '0;
            r_idx   <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_tmo   <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            r_run <= 1'b1;

            if (w_accept) begin
                r_tmo <= '0;
            end else if (w_tmo_en) begin
                r_tmo <= r_tmo + c_TMO_W'(1);
            end

            case (r_state)
                ST_LEN: begin
                    // Only meaningful when N fits the ROM; otherwise ERR.
                    if (w_last) begin
                        r_len <= w_word[ADDR_W:0];
                        r_idx <= '0;
                    end
                end
                ST_DATA: begin
                    // Address and word are staged so they are stable for
                    // the whole WRITE cycle and held afterwards.
                    if (w_last) begin
                        r_waddr <= r_idx[ADDR_W-1:0];
                        r_wdata <= w_word;
`ifdef ROM_LOADER_CHECKSUM_EN
                        r_sum   <= r_sum + w_word;
`endif
                    end
                end
                ST_WRITE: begin
                    r_idx <= w_idx_inc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : rom_loader
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_loader
//  Description : Self-checking bench for rom_loader. A table of images is
//                streamed after a reset each, followed by hand-written
//                sequences for reset behaviour, idle timeout, back-to-back
//                streaming, mid-image reset and the length boundary.
//                Honours ROM_LOADER_CHECKSUM_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_loader;

    localparam int ADDR_W = 12;
    localparam int TMO    = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = 8'h00;
    logic              s_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_waddr;
    logic [31:0]       rom_wdata;
    logic              core_rst_n;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    rom_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .rom_we     (rom_we),
        .rom_waddr  (rom_waddr),
        .rom_wdata  (rom_wdata),
        .core_rst_n (core_rst_n),
        .done       (done),
        .err        (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ROM write log, ready-drop counter and done/core_rst_n agreement
    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];
    int                drops = 0;
    bit                drop_en = 1'b0;
    int                dc_bad = 0;
    logic [7:0]        bq[$];

    always @(negedge clk) begin
        if (rom_we) begin
            wa_q.push_back(rom_waddr);
            wd_q.push_back(rom_wdata);
        end
        if (drop_en && !s_ready && !done && !err) drops++;
        if (done !== core_rst_n) dc_bad++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input int nb);
        for (int i = 0; i < nb; i++) bq.push_back(w[8*i +: 8]);
    endtask

    task automatic send_all();
        for (int i = 0; i < bq.size(); i++) begin
            int t;
            t = 0;
            s_valid = 1'b1;
            s_data  = bq[i];
            @(negedge clk);
            while (!s_ready && t < 50) begin
                t++;
                @(negedge clk);
            end
            if (!s_ready) begin
                chk("send_ready", {31'd0, s_ready}, 32'd1);
                break;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        bq.delete();
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        wa_q.delete();
        wd_q.delete();
        dc_bad = 0;
        drops  = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!(done || err) && t < 3*TMO + 40) begin
            @(negedge clk);
            t++;
        end
        chk("end_reached", {31'd0, done | err}, 32'd1);
    endtask

    // Appends the checksum when the whole image was sent (checksum builds).
    task automatic push_csum(input logic [31:0] hdr, input int nb,
                             input logic [3:0][31:0] w, input bit bad);
`ifdef ROM_LOADER_CHECKSUM_EN
        logic [31:0] cs;
        cs = 32'd0;
        if (nb == 4*int'(hdr)) begin
            for (int k = 0; k < int'(hdr) && k < 4; k++) cs = cs + w[k];
            if (bad) cs = cs + 32'd1;
            push_word(cs, 4);
        end
`else
        if (bad && nb < 0 && hdr == 32'd0 && w == '0) bq.delete();
`endif
    endtask

    typedef struct {
        string           name;
        logic [31:0]     hdr;
        int              nb;
        logic [3:0][31:0] w;
        bit              bad_cs;
        bit              x_done;
        bit              x_err;
        int              x_we;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [31:0] h, input int nb,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input bit bad,
                                input bit xd, input bit xe, input int xw);
        vec_t r;
        r.name = nm; r.hdr = h; r.nb = nb; r.w = {32'd0, w2, w1, w0};
        r.bad_cs = bad; r.x_done = xd; r.x_err = xe; r.x_we = xw;
        return r;
    endfunction

    vec_t vt[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][31:0] img;

        vt[0] = mk("img2",     32'd2,        8, 32'h00000013, 32'h00100093, 32'h0, 1'b0, 1'b1, 1'b0, 2);
        vt[1] = mk("len_over", 32'h00001001, 0, 32'h0, 32'h0, 32'h0,                1'b0, 1'b0, 1'b1, 0);
        vt[2] = mk("idle_tmo", 32'd1,        2, 32'hAABBCCDD, 32'h0, 32'h0,          1'b0, 1'b0, 1'b1, 0);
        vt[3] = mk("len_zero", 32'd0,        0, 32'h0, 32'h0, 32'h0,                 1'b0, 1'b1, 1'b0, 0);
        vt[4] = mk("img3",     32'd3,       12, 32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 3);
        vt[5] = mk("cs_good",  32'd2,        8, 32'd1, 32'd2, 32'h0,                 1'b0, 1'b1, 1'b0, 2);
`ifdef ROM_LOADER_CHECKSUM_EN
        vt[6] = mk("cs_bad",   32'd2,        8, 32'd1, 32'd2, 32'h0,                 1'b1, 1'b0, 1'b1, 2);
`else
        vt[6] = mk("cs_bad",   32'd2,        8, 32'd1, 32'd2, 32'h0,                 1'b1, 1'b1, 1'b0, 2);
`endif

        // ---- asynchronous reset values, then ready after release ----
        #1 rst = 1'b0;
        #3;
        chk("rst_s_ready",    {31'd0, s_ready},    32'd0);
        chk("rst_rom_we",     {31'd0, rom_we},     32'd0);
        chk("rst_waddr",      32'(rom_waddr),      32'd0);
        chk("rst_wdata",      rom_wdata,           32'd0);
        chk("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        chk("rst_done",       {31'd0, done},       32'd0);
        chk("rst_err",        {31'd0, err},        32'd0);
        repeat (2) @(negedge clk);
        dc_bad = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

        // ---- no timeout while idle before the first length byte ----
        repeat (3*TMO) @(negedge clk);
        chk("len_idle_err",   {31'd0, err},     32'd0);
        chk("len_idle_ready", {31'd0, s_ready}, 32'd1);

        // ---- table of images ----
        for (int v = 0; v < 7; v++) begin
            do_reset();
            push_word(vt[v].hdr, 4);
            for (int k = 0; k < vt[v].nb; k++) bq.push_back(vt[v].w[k/4][8*(k%4) +: 8]);
            push_csum(vt[v].hdr, vt[v].nb, vt[v].w, vt[v].bad_cs);
            send_all();
            wait_end();
            @(negedge clk);
            chk({vt[v].name, "_done"},  {31'd0, done},       {31'd0, vt[v].x_done});
            chk({vt[v].name, "_err"},   {31'd0, err},        {31'd0, vt[v].x_err});
            chk({vt[v].name, "_core"},  {31'd0, core_rst_n}, {31'd0, vt[v].x_done});
            chk({vt[v].name, "_ready"}, {31'd0, s_ready},    32'd0);
            chk({vt[v].name, "_nwe"},   32'(wa_q.size()),    32'(vt[v].x_we));
            chk({vt[v].name, "_dc"},    32'(dc_bad),         32'd0);
            for (int k = 0; k < vt[v].x_we && k < wa_q.size(); k++) begin
                chk({vt[v].name, "_addr"}, 32'(wa_q[k]), 32'(k));
                chk({vt[v].name, "_data"}, wd_q[k],      vt[v].w[k]);
            end
        end

        // ---- idle timeout boundary after two data bytes ----
        do_reset();
        push_word(32'd1, 4);
        push_word(32'h00C0FFEE, 2);
        send_all();
        repeat (TMO - 2) @(negedge clk);
        chk("tmo_early_err", {31'd0, err}, 32'd0);
        repeat (4) @(negedge clk);
        chk("tmo_late_err",  {31'd0, err}, 32'd1);
        chk("tmo_nwe",       32'(wa_q.size()), 32'd0);

        // ---- back-to-back stream: one ready drop per word ----
        do_reset();
        img = {32'hDDEEFF00, 32'h99AABBCC, 32'h55667788, 32'h11223344};
        push_word(32'd4, 4);
        for (int k = 0; k < 4; k++) push_word(img[k], 4);
        push_csum(32'd4, 16, img, 1'b0);
        drop_en = 1'b1;
        send_all();
        wait_end();
        drop_en = 1'b0;
        chk("b2b_drops", 32'(drops), 32'd4);
        chk("b2b_done",  {31'd0, done}, 32'd1);
        chk("b2b_nwe",   32'(wa_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < wa_q.size(); k++) begin
            chk("b2b_addr", 32'(wa_q[k]), 32'(k));
            chk("b2b_data", wd_q[k],      img[k]);
        end

        // ---- reset after 6 of 12 bytes, then full image again ----
        do_reset();
        push_word(32'd2, 4);
        push_word(32'h77665544, 2);
        send_all();
        do_reset();
        img = {32'd0, 32'd0, 32'h0BADC0DE, 32'hCAFEF00D};
        push_word(32'd2, 4);
        push_word(img[0], 4);
        push_word(img[1], 4);
        push_csum(32'd2, 8, img, 1'b0);
        send_all();
        wait_end();
        chk("restart_done", {31'd0, done}, 32'd1);
        chk("restart_nwe",  32'(wa_q.size()), 32'd2);
        for (int k = 0; k < 2 && k < wa_q.size(); k++) begin
            chk("restart_addr", 32'(wa_q[k]), 32'(k));
            chk("restart_data", wd_q[k],      img[k]);
        end

        // ---- asynchronous reset from DONE clears outputs immediately ----
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_done",  {31'd0, done},       32'd0);
        chk("async_core",  {31'd0, core_rst_n}, 32'd0);
        chk("async_wdata", rom_wdata,           32'd0);
        chk("async_waddr", 32'(rom_waddr),      32'd0);
        chk("async_ready", {31'd0, s_ready},    32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ---- length equal to ROM depth is accepted ----
        do_reset();
        push_word(32'h00001000, 4);
        send_all();
        repeat (2) @(negedge clk);
        chk("depth_err",   {31'd0, err},     32'd0);
        chk("depth_ready", {31'd0, s_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rom_loader
`default_nettype wire
